img_frame_buffer: RTL and testbench

- Memory-side responder for the Gaussian convolution engine's two SRAM ports.
- Holds the source image bank and serves the engine's pixel reads (ren/x/y -> rdat, 1-cycle latency) with zero padding outside the frame.
- Holds the result bank and absorbs the engine's blurred-pixel writes.
- Host side: loads the source frame over a valid/ready stream and dumps the result frame over a valid/ready stream, both in raster order.

---
 rtl/img_frame_buffer_pkg.sv | 24 ++
 rtl/img_frame_buffer_if.sv | 49 ++++
 rtl/img_frame_buffer_raster_counter.sv | 50 +++++
 rtl/img_frame_buffer.sv | 174 +++++++++++++++++
 tb/tb_img_frame_buffer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_frame_buffer_pkg.sv
// Shared types and helpers for the frame buffer that sits between the host stream and the
// Gaussian convolution engine.
package img_pkg;

    localparam int unsigned X_MAX_DEF = 200;
    localparam int unsigned Y_MAX_DEF = 200;
    localparam int unsigned XW = $clog2(X_MAX_DEF) + 1;
    localparam int unsigned YW = $clog2(Y_MAX_DEF) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StArmed,
        StDumpRd,
        StDumpOut
    } fb_state_t;

    // Both banks are stored with a fixed row pitch of the maximum frame width.
    function automatic int unsigned lin_index(input int unsigned x, input int unsigned y,
                                              input int unsigned stride);
        return y * stride + x;
    endfunction

endpackage

// File: rtl/img_frame_buffer_if.sv
// Host stream and engine SRAM-port signals of the frame buffer.
interface img_frame_buffer_if #(
    parameter int unsigned X_MAX       = img_pkg::X_MAX_DEF,
    parameter int unsigned Y_MAX       = img_pkg::Y_MAX_DEF,
    parameter int unsigned PIXEL_DEPTH = 8
);
    localparam int unsigned MXW = $clog2(X_MAX);
    localparam int unsigned MYW = $clog2(Y_MAX);

    logic [MXW-1:0]         max_x;
    logic [MYW-1:0]         max_y;
    logic                   load_start;
    logic                   load_valid;
    logic [PIXEL_DEPTH-1:0] load_data;
    logic                   load_ready;
    logic                   frame_loaded;
    logic [MXW:0]           x_addr_img;
    logic [MYW:0]           y_addr_img;
    logic                   ren_img;
    logic [PIXEL_DEPTH-1:0] rdat_img;
    logic [MXW:0]           x_addr_conv;
    logic [MYW:0]           y_addr_conv;
    logic                   wen_conv;
    logic [PIXEL_DEPTH-1:0] wdat_conv;
    logic                   conv_done;
    logic                   dump_start;
    logic                   dump_valid;
    logic [PIXEL_DEPTH-1:0] dump_data;
    logic                   dump_ready;
    logic                   dump_done;
    logic                   access_err;

    modport slave (
        input  max_x, max_y, load_start, load_valid, load_data,
        input  x_addr_img, y_addr_img, ren_img,
        input  x_addr_conv, y_addr_conv, wen_conv, wdat_conv, conv_done,
        input  dump_start, dump_ready,
        output load_ready, frame_loaded, rdat_img, dump_valid, dump_data, dump_done, access_err
    );

    modport master (
        output max_x, max_y, load_start, load_valid, load_data,
        output x_addr_img, y_addr_img, ren_img,
        output x_addr_conv, y_addr_conv, wen_conv, wdat_conv, conv_done,
        output dump_start, dump_ready,
        input  load_ready, frame_loaded, rdat_img, dump_valid, dump_data, dump_done, access_err
    );

endinterface

// File: rtl/img_frame_buffer_raster_counter.sv
// Raster-order (x, y) walker bounded by the latched frame limits; shared by load and dump.
module raster_counter #(
    parameter int unsigned XWidth = 8,
    parameter int unsigned YWidth = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [XWidth-1:0] max_x_i,
    input  logic [YWidth-1:0] max_y_i,
    output logic [XWidth-1:0] cx_o,
    output logic [YWidth-1:0] cy_o,
    output logic              last_o
);

    logic [XWidth-1:0] cx_q, cx_d;
    logic [YWidth-1:0] cy_q, cy_d;

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = (cx_q == max_x_i) && (cy_q == max_y_i);

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (advance_i) begin
            if (cx_q == max_x_i) begin
                cx_d = '0;
                cy_d = last_o ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/img_frame_buffer.sv
// Source/result image banks serving the convolution engine, loaded and dumped by the host
// as raster-order valid/ready streams.
module img_frame_buffer
    import img_pkg::*;
#(
    parameter int unsigned X_MAX       = 200,
    parameter int unsigned Y_MAX       = 200,
    parameter int unsigned PIXEL_DEPTH = 8
) (
    input logic               clk,
    input logic               n_rst,
    img_frame_buffer_if.slave fb_io
);

    localparam int unsigned MXW   = $clog2(X_MAX);
    localparam int unsigned MYW   = $clog2(Y_MAX);
    localparam int unsigned Depth = X_MAX * Y_MAX;
    localparam int unsigned AW    = $clog2(Depth);

    logic [PIXEL_DEPTH-1:0] src_mem [Depth];
    logic [PIXEL_DEPTH-1:0] dst_mem [Depth];

    fb_state_t              state_q, state_d;
    logic [MXW-1:0]         max_x_q, max_x_d;
    logic [MYW-1:0]         max_y_q, max_y_d;
    logic                   frame_loaded_q, frame_loaded_d;
    logic                   access_err_q, access_err_d;
    logic                   dump_done_q, dump_done_d;
    logic [PIXEL_DEPTH-1:0] rdat_q, dump_data_q;

    logic [MXW-1:0] cx;
    logic [MYW-1:0] cy;
    logic           last;
    logic           cnt_clear, load_hs, dump_hs;
    logic           img_rd_ok, conv_wr;
    logic [AW-1:0]  cnt_addr, img_addr, conv_addr;

    raster_counter #(
        .XWidth (MXW),
        .YWidth (MYW)
    ) u_raster_counter (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (cnt_clear),
        .advance_i (load_hs || dump_hs),
        .max_x_i   (max_x_q),
        .max_y_i   (max_y_q),
        .cx_o      (cx),
        .cy_o      (cy),
        .last_o    (last)
    );

    assign cnt_addr  = AW'(lin_index(32'(cx), 32'(cy), X_MAX));
    assign img_addr  = AW'(lin_index(32'(fb_io.x_addr_img), 32'(fb_io.y_addr_img), X_MAX));
    assign conv_addr = AW'(lin_index(32'(fb_io.x_addr_conv), 32'(fb_io.y_addr_conv), X_MAX));

    // Outside the loaded frame the engine sees zero padding; writes there are dropped.
    assign img_rd_ok = (state_q == StArmed)
                    && (fb_io.x_addr_img <= {1'b0, max_x_q})
                    && (fb_io.y_addr_img <= {1'b0, max_y_q});
    assign conv_wr   = (state_q == StArmed) && fb_io.wen_conv
                    && (fb_io.x_addr_conv <= {1'b0, max_x_q})
                    && (fb_io.y_addr_conv <= {1'b0, max_y_q});

    always_comb begin
        state_d        = state_q;
        max_x_d        = max_x_q;
        max_y_d        = max_y_q;
        frame_loaded_d = frame_loaded_q;
        access_err_d   = access_err_q;
        dump_done_d    = 1'b0;
        cnt_clear      = 1'b0;
        load_hs        = 1'b0;
        dump_hs        = 1'b0;

        // Set before the state decode so a load_start in the same cycle still clears it.
        if ((state_q != StArmed) && (fb_io.ren_img || fb_io.wen_conv)) begin
            access_err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (fb_io.load_start) begin
                    state_d        = StLoad;
                    cnt_clear      = 1'b1;
                    max_x_d        = fb_io.max_x;
                    max_y_d        = fb_io.max_y;
                    frame_loaded_d = 1'b0;
                    access_err_d   = 1'b0;
                end else if (fb_io.dump_start) begin
                    state_d   = StDumpRd;
                    cnt_clear = 1'b1;
                end
            end
            StLoad: begin
                if (fb_io.load_valid) begin
                    load_hs = 1'b1;
                    if (last) begin
                        state_d        = StArmed;
                        frame_loaded_d = 1'b1;
                    end
                end
            end
            StArmed: begin
                if (fb_io.conv_done) begin
                    state_d = StIdle;
                end
            end
            StDumpRd: state_d = StDumpOut;
            StDumpOut: begin
                if (fb_io.dump_ready) begin
                    dump_hs = 1'b1;
                    if (last) begin
                        state_d     = StIdle;
                        dump_done_d = 1'b1;
                    end else begin
                        state_d = StDumpRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q        <= StIdle;
            max_x_q        <= '0;
            max_y_q        <= '0;
            frame_loaded_q <= 1'b0;
            access_err_q   <= 1'b0;
            dump_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            max_x_q        <= max_x_d;
            max_y_q        <= max_y_d;
            frame_loaded_q <= frame_loaded_d;
            access_err_q   <= access_err_d;
            dump_done_q    <= dump_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst && load_hs) begin
            src_mem[cnt_addr] <= fb_io.load_data;
        end
        if (n_rst && conv_wr) begin
            dst_mem[conv_addr] <= fb_io.wdat_conv;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rdat_q      <= '0;
            dump_data_q <= '0;
        end else begin
            if (fb_io.ren_img) begin
                rdat_q <= img_rd_ok ? src_mem[img_addr] : '0;
            end
            if (state_q == StDumpRd) begin
                dump_data_q <= dst_mem[cnt_addr];
            end
        end
    end

    assign fb_io.load_ready   = (state_q == StLoad);
    assign fb_io.frame_loaded = frame_loaded_q;
    assign fb_io.rdat_img     = rdat_q;
    assign fb_io.dump_valid   = (state_q == StDumpOut);
    assign fb_io.dump_data    = dump_data_q;
    assign fb_io.dump_done    = dump_done_q;
    assign fb_io.access_err   = access_err_q;

endmodule

// File: tb/tb_img_frame_buffer.sv
// Scoreboard bench for img_frame_buffer: directed scenarios plus randomized frames, checked
// against an array model of both banks.
module tb_img_frame_buffer;

    localparam int unsigned X_MAX = 200;
    localparam int unsigned Y_MAX = 200;
    localparam int unsigned PD    = 8;
    localparam int unsigned MXW   = $clog2(X_MAX);
    localparam int unsigned MYW   = $clog2(Y_MAX);

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    img_frame_buffer_if #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .PIXEL_DEPTH(PD)) fb ();

    img_frame_buffer #(
        .X_MAX       (X_MAX),
        .Y_MAX       (Y_MAX),
        .PIXEL_DEPTH (PD)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .fb_io (fb)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: frame limits, engine-window flag, sticky error and both banks.
    int src_m [int];
    int dst_m [int];
    int mx_m = 0, my_m = 0;
    bit armed_m = 0;
    bit err_m   = 0;

    int rd_q   [$];
    int dump_q [$];
    bit rd_due = 0, hold_due = 0, done_due = 0;
    logic [PD-1:0] hold_val;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected read and dump values whenever the DUT presents them.
    always @(negedge clk) begin
        if (!n_rst) begin
            rd_due   = 0;
            hold_due = 0;
            done_due = 0;
        end else begin
            if (rd_due) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rdat_unexpected: got %0d, expected no read", fb.rdat_img);
                end else begin
                    check("rdat_img", 32'(fb.rdat_img), rd_q.pop_front());
                end
            end
            rd_due = fb.ren_img;

            if (done_due) begin
                check("dump_done_pulse", 32'(fb.dump_done), 1);
                done_due = 0;
            end else begin
                check("dump_done_quiet", 32'(fb.dump_done), 0);
            end
            if (fb.dump_done) done_cnt++;

            if (fb.dump_valid) begin
                if (hold_due) check("dump_hold", 32'(fb.dump_data), 32'(hold_val));
                if (dump_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL dump_unexpected: got valid data %0d, expected none",
                             fb.dump_data);
                    hold_due = 0;
                end else if (fb.dump_ready) begin
                    check("dump_data", 32'(fb.dump_data), dump_q.pop_front());
                    if (dump_q.size() == 0) done_due = 1;
                    hold_due = 0;
                end else begin
                    hold_due = 1;
                    hold_val = fb.dump_data;
                end
            end else begin
                hold_due = 0;
            end
        end
    end

    task automatic idle_inputs();
        fb.max_x       = '0;
        fb.max_y       = '0;
        fb.load_start  = 0;
        fb.load_valid  = 0;
        fb.load_data   = '0;
        fb.x_addr_img  = '0;
        fb.y_addr_img  = '0;
        fb.ren_img     = 0;
        fb.x_addr_conv = '0;
        fb.y_addr_conv = '0;
        fb.wen_conv    = 0;
        fb.wdat_conv   = '0;
        fb.conv_done   = 0;
        fb.dump_start  = 0;
        fb.dump_ready  = 0;
    endtask

    // Starts a load; stops after stop_after handshakes if that comes before the frame end.
    task automatic load_frame(input int mx, input int my, input bit rnd, input bit dump_too,
                              input int stop_after);
        int hs = 0, cyc = 0, d = 0;
        int total = (mx + 1) * (my + 1);
        fb.max_x      = MXW'(mx);
        fb.max_y      = MYW'(my);
        fb.load_start = 1;
        fb.dump_start = dump_too;
        mx_m = mx;
        my_m = my;
        armed_m = 0;
        err_m   = 0;
        step();
        fb.load_start = 0;
        check("load_ready_on_entry", 32'(fb.load_ready), 1);
        check("frame_loaded_cleared", 32'(fb.frame_loaded), 0);
        check("access_err_cleared", 32'(fb.access_err), 0);
        if (dump_too) check("no_dump_on_overlap", 32'(fb.dump_valid), 0);
        while (hs < total && hs < stop_after && cyc < 4000) begin
            fb.load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            d = rnd ? int'($urandom_range(0, 255)) : hs + 1;
            fb.load_data = PD'(d);
            @(negedge clk);
            if (fb.load_valid && fb.load_ready) begin
                src_m[(hs / (mx + 1)) * X_MAX + (hs % (mx + 1))] = d;
                hs++;
                if (hs == total) check("frame_loaded_before_last", 32'(fb.frame_loaded), 0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        fb.load_valid = 0;
        fb.dump_start = 0;
        if (cyc >= 4000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL load_timeout: got %0d handshakes, expected %0d", hs, total);
        end else if (hs == total) begin
            armed_m = 1;
            check("frame_loaded_after_last", 32'(fb.frame_loaded), 1);
            check("load_ready_after_last", 32'(fb.load_ready), 0);
        end
    endtask

    task automatic engine_cycle(input bit ren, input int rx, input int ry,
                                input bit wen, input int wx, input int wy, input int wd);
        fb.ren_img     = ren;
        fb.x_addr_img  = (MXW + 1)'(rx);
        fb.y_addr_img  = (MYW + 1)'(ry);
        fb.wen_conv    = wen;
        fb.x_addr_conv = (MXW + 1)'(wx);
        fb.y_addr_conv = (MYW + 1)'(wy);
        fb.wdat_conv   = PD'(wd);
        if (ren) begin
            if (armed_m && rx <= mx_m && ry <= my_m) rd_q.push_back(src_m[ry * X_MAX + rx]);
            else rd_q.push_back(0);
            if (!armed_m) err_m = 1;
        end
        if (wen) begin
            if (!armed_m) err_m = 1;
            else if (wx <= mx_m && wy <= my_m) dst_m[wy * X_MAX + wx] = wd;
        end
        step();
        fb.ren_img  = 0;
        fb.wen_conv = 0;
    endtask

    task automatic finish_conv();
        fb.conv_done = 1;
        step();
        fb.conv_done = 0;
        armed_m = 0;
        check("frame_loaded_after_done", 32'(fb.frame_loaded), 1);
        check("idle_after_done", 32'(fb.load_ready), 0);
    endtask

    task automatic dump_frame(input bit toggle);
        int cyc = 0;
        int done_before = done_cnt;
        for (int y = 0; y <= my_m; y++)
            for (int x = 0; x <= mx_m; x++) dump_q.push_back(dst_m[y * X_MAX + x]);
        fb.dump_start = 1;
        step();
        fb.dump_start = 0;
        while ((dump_q.size() != 0 || done_due) && cyc < 2000) begin
            fb.dump_ready = toggle ? cyc[0] : 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        fb.dump_ready = 0;
        step();
        if (cyc >= 2000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dump_timeout: got %0d pixels left, expected 0", dump_q.size());
            dump_q.delete();
        end
        check("dump_done_count", done_cnt - done_before, 1);
        check("dump_idle_after", 32'(fb.dump_valid), 0);
    endtask

    initial begin
        idle_inputs();
        n_rst = 0;
        repeat (3) step();
        check("rst_load_ready", 32'(fb.load_ready), 0);
        check("rst_frame_loaded", 32'(fb.frame_loaded), 0);
        check("rst_dump_valid", 32'(fb.dump_valid), 0);
        check("rst_dump_done", 32'(fb.dump_done), 0);
        check("rst_access_err", 32'(fb.access_err), 0);
        check("rst_rdat", 32'(fb.rdat_img), 0);
        check("rst_dump_data", 32'(fb.dump_data), 0);
        n_rst = 1;
        step();

        // 4x3 frame of 1..12, armed reads including padding.
        load_frame(3, 2, 0, 0, 1000);
        engine_cycle(1, 2, 1, 0, 0, 0, 0);
        engine_cycle(1, 4, 0, 0, 0, 0, 0);
        engine_cycle(1, 0, 3, 0, 0, 0, 0);
        engine_cycle(1, 0, 0, 0, 0, 0, 0);
        step();
        check("armed_no_err", 32'(fb.access_err), 32'(err_m));
        check("rdat_holds", 32'(fb.rdat_img), 1);

        for (int i = 0; i < 12; i++) engine_cycle(0, 0, 0, 1, i % 4, i / 4, 100 + i);
        finish_conv();
        dump_frame(1);

        // Engine accesses while idle: zero read, dropped write, sticky error.
        engine_cycle(1, 1, 1, 1, 0, 0, 55);
        step();
        check("idle_access_err", 32'(fb.access_err), 1);
        dump_frame(1);
        check("err_sticky", 32'(fb.access_err), 32'(err_m));

        // Simultaneous starts pick the load; dump_start during the load is ignored.
        load_frame(3, 2, 1, 1, 1000);
        check("err_cleared_by_load", 32'(fb.access_err), 0);
        finish_conv();

        // Reset after five pixels, then a clean reload.
        load_frame(3, 2, 0, 0, 5);
        n_rst = 0;
        step();
        check("midrst_load_ready", 32'(fb.load_ready), 0);
        check("midrst_frame_loaded", 32'(fb.frame_loaded), 0);
        check("midrst_dump_valid", 32'(fb.dump_valid), 0);
        n_rst = 1;
        armed_m = 0;
        err_m   = 0;
        step();
        load_frame(3, 2, 0, 0, 1000);
        engine_cycle(1, 3, 2, 0, 0, 0, 0);
        finish_conv();

        // Randomized frames with interleaved reads/writes and random dump back-pressure.
        for (int f = 0; f < 6; f++) begin
            int mx = int'($urandom_range(0, 9));
            int my = int'($urandom_range(0, 6));
            load_frame(mx, my, 1, 0, 100000);
            for (int y = 0; y <= my; y++)
                for (int x = 0; x <= mx; x++)
                    engine_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, mx + 3)),
                                 int'($urandom_range(0, my + 3)), 1, x, y,
                                 int'($urandom_range(0, 255)));
            for (int k = 0; k < 30; k++)
                engine_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, mx + 3)),
                             int'($urandom_range(0, my + 3)), 1'($urandom_range(0, 1)),
                             int'($urandom_range(0, mx + 3)), int'($urandom_range(0, my + 3)),
                             int'($urandom_range(0, 255)));
            step();
            check("rand_access_err", 32'(fb.access_err), 32'(err_m));
            finish_conv();
            dump_frame(0);
        end

        repeat (3) step();
        check("rd_queue_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
